data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
- Two-port front end for the shared data word memory in the multi-core logic unit. Two IL cores issue word read, word write or single-bit write requests.
- The block arbitrates round-robin and drives the memory's single port (M_WE/M_A/M_DI, 1-cycle registered-address read).
- It returns read data with a valid strobe. Single-bit writes are done as atomic read-modify-write sequences.

Parameters:
- AW, 16, address width (matches memory A).
- DW, 32, data word width.
- BW, 5, bit-index width; must satisfy 2**BW == DW.

Ports:
- CLK  in  1  clock, all logic on posedge.
- RST  in  1  synchronous reset, active-high.
- C0_REQ, C1_REQ  in  1  request, held until ACK.
- C0_OP, C1_OP  in  2  00 word read, 01 word write, 10 bit write, 11 reserved (executes as word read).
- C0_A, C1_A  in  AW  word address.
- C0_DI, C1_DI  in  DW  write data (OP=01).
- C0_BIT, C1_BIT  in  BW  bit index (OP=10).
- C0_BV, C1_BV  in  1  bit value (OP=10).
- C0_ACK, C1_ACK  out  1  one-cycle grant/complete pulse.
- C0_DQ, C1_DQ  out  DW  read data, held until the next read for that core.
- C0_DV, C1_DV  out  1  one-cycle read-data-valid pulse.
- M_WE  out  1  memory write enable.
- M_A  out  AW  memory address.
- M_DI  out  DW  memory write data.
- M_DQ  in  DW  memory read data; valid the cycle after M_A is sampled.

Behaviour:
- Reset:
  - All outputs 0; FSM=IDLE; round-robin pointer LAST=1, so core 0 wins the first tie.
  - Reset mid-operation abandons any access; an RMW in progress performs no write.
- All outputs are registered. FSM states: IDLE, ISSUE, BRD, BMOD, BWR.
- Arbitration (IDLE only):
  - Sample REQs at edge E0.
  - One requester: grant it. Both requesting: grant the core != LAST.
  - Update LAST to the granted core; latch OP/A/DI/BIT/BV.
  - Non-granted REQ keeps waiting; it is never dropped.
- Word op (OP 00/01/11):
  - E0: IDLE->ISSUE. M_A=A, M_WE=(OP==01), M_DI=DI, Cx_ACK=1 during ISSUE.
  - E1: memory samples the request; FSM->IDLE; M_WE=0, ACK=0.
  - Read: M_DQ valid in the cycle after ISSUE. Registered at E2 into Cx_DQ with Cx_DV=1 for one cycle. DV is high 3 cycles after E0.
- Bit write (OP 10):
  - E0: ->BRD; M_A=A, M_WE=0.
  - E1: ->BMOD; M_DQ is valid in BMOD.
  - E2: ->BWR; M_DI = M_DQ with bit BIT forced to BV (all other bits unchanged); M_WE=1; Cx_ACK=1.
  - E3: write commits; ->IDLE; M_WE=0.
  - The arbiter stays locked BRD..BWR, so the other core cannot interleave (atomic).
- Handshake:
  - Core drops REQ in its ACK cycle.
  - REQ still high at the edge after ACK counts as a new request.
  - Earliest next grant is at the edge that returns the FSM to IDLE, plus one cycle in IDLE.
  - Maximum issue rate: one word op per 2 cycles.
- Ordering: accesses are strictly serialized. A read after a write to the same address (either core) returns the new data.
- A read's DV may coincide with the next grant's ACK; both strobes are independent per core.
- M_A holds its last value in IDLE; M_WE=0 in every state except ISSUE(write) and BWR.

Optional Feature:
- Macro DMEM_BIT_RMW_EN.
- Defined: bit write via BRD/BMOD/BWR as above.
- Undefined:
  - BRD/BMOD/BWR states and the BIT/BV datapath are not built.
  - OP=10 executes as a word read (ISSUE path, DV returned). Memory is never written for OP=10.

Test Plan:
- Reset then C0 write A=0x0010 DI=0xDEADBEEF; C0 read 0x0010 -> C0_ACK 1 cycle after request edge; C0_DV 3 cycles after read request edge, C0_DQ=0xDEADBEEF.
- C0 and C1 both REQ read at the same edge after reset -> C0 ACK first, C1 ACK next grant. Repeat simultaneous -> C1 first (round robin).
- Memory 0x0020=0x00000000, C1 bit write BIT=31 BV=1 -> M_WE only in BWR with M_DI=0x80000000. Then BIT=0 BV=1 -> 0x80000001. Then BIT=31 BV=0 -> 0x00000001.
- C0 bit write in flight while C1 REQ write 0x0020=0xFFFFFFFF -> C1 ACK only after BWR. Final read returns 0xFFFFFFFF.
- RST asserted during BMOD -> next cycle all outputs 0, memory location unchanged on readback.
- Macro undefined: OP=10 at 0x0030 (holding 0x12345678) -> DV with 0x12345678, M_WE never 1.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Round-robin two-core front end for the shared data word memory; 1-cycle ACK, read data 3 cycles after grant.
// Losing core holds REQ until granted; bit writes are atomic RMW when DMEM_BIT_RMW_EN is defined.
module data_mem_arbiter #(
  parameter int AW = 16,
  parameter int DW = 32,
  parameter int BW = 5
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          C0_REQ,
  input  logic [1:0]    C0_OP,
  input  logic [AW-1:0] C0_A,
  input  logic [DW-1:0] C0_DI,
  input  logic [BW-1:0] C0_BIT,
  input  logic          C0_BV,
  input  logic          C1_REQ,
  input  logic [1:0]    C1_OP,
  input  logic [AW-1:0] C1_A,
  input  logic [DW-1:0] C1_DI,
  input  logic [BW-1:0] C1_BIT,
  input  logic          C1_BV,
  output logic          C0_ACK,
  output logic [DW-1:0] C0_DQ,
  output logic          C0_DV,
  output logic          C1_ACK,
  output logic [DW-1:0] C1_DQ,
  output logic          C1_DV,
  output logic          M_WE,
  output logic [AW-1:0] M_A,
  output logic [DW-1:0] M_DI,
  input  logic [DW-1:0] M_DQ
);

`ifdef DMEM_BIT_RMW_EN
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_BRD, S_BMOD, S_BWR} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_ISSUE} state_t;
`endif

  state_t        r_state;
  logic          r_last;
  logic          r_core;
  logic [1:0]    r_op;
  logic          r_rd_pend;
  logic          r_rd_core;

  logic          w_gnt_vld;
  logic          w_gnt_core;
  logic [1:0]    w_op;
  logic [AW-1:0] w_a;
  logic [DW-1:0] w_di;
  state_t        w_gnt_state;

  // On a tie the core that did not win last time gets the grant.
  assign w_gnt_vld  = C0_REQ | C1_REQ;
  assign w_gnt_core = (C0_REQ & C1_REQ) ? ~r_last : C1_REQ;
  assign w_op       = w_gnt_core ? C1_OP : C0_OP;
  assign w_a        = w_gnt_core ? C1_A  : C0_A;
  assign w_di       = w_gnt_core ? C1_DI : C0_DI;

`ifdef DMEM_BIT_RMW_EN
  logic [BW-1:0] r_bit;
  logic          r_bv;
  logic [BW-1:0] w_bit;
  logic          w_bv;
  logic [DW-1:0] w_rmw;

  assign w_bit       = w_gnt_core ? C1_BIT : C0_BIT;
  assign w_bv        = w_gnt_core ? C1_BV  : C0_BV;
  assign w_gnt_state = (w_op == 2'b10) ? S_BRD : S_ISSUE;

  always_comb begin
    w_rmw        = M_DQ;
    w_rmw[r_bit] = r_bv;
  end
`else
  logic w_unused_bits;
  assign w_unused_bits = ^{C0_BIT, C1_BIT, C0_BV, C1_BV};
  assign w_gnt_state   = S_ISSUE;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_last    <= 1'b1;
      r_core    <= 1'b0;
      r_op      <= 2'b00;
      r_rd_pend <= 1'b0;
      r_rd_core <= 1'b0;
      C0_ACK    <= 1'b0;
      C1_ACK    <= 1'b0;
      C0_DV     <= 1'b0;
      C1_DV     <= 1'b0;
      C0_DQ     <= '0;
      C1_DQ     <= '0;
      M_WE      <= 1'b0;
      M_A       <= '0;
      M_DI      <= '0;
`ifdef DMEM_BIT_RMW_EN
      r_bit     <= '0;
      r_bv      <= 1'b0;
`endif
    end else begin
      C0_ACK    <= 1'b0;
      C1_ACK    <= 1'b0;
      C0_DV     <= 1'b0;
      C1_DV     <= 1'b0;
      M_WE      <= 1'b0;
      r_rd_pend <= 1'b0;

      // Memory data for a read issued two edges ago is on M_DQ now.
      if (r_rd_pend) begin
        if (r_rd_core) begin
          C1_DQ <= M_DQ;
          C1_DV <= 1'b1;
        end else begin
          C0_DQ <= M_DQ;
          C0_DV <= 1'b1;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (w_gnt_vld) begin
            r_last  <= w_gnt_core;
            r_core  <= w_gnt_core;
            r_op    <= w_op;
            M_A     <= w_a;
            r_state <= w_gnt_state;
`ifdef DMEM_BIT_RMW_EN
            r_bit   <= w_bit;
            r_bv    <= w_bv;
`endif
            if (w_gnt_state == S_ISSUE) begin
              M_WE   <= (w_op == 2'b01);
              M_DI   <= w_di;
              C0_ACK <= ~w_gnt_core;
              C1_ACK <= w_gnt_core;
            end
          end
        end
        S_ISSUE: begin
          r_state <= S_IDLE;
          if (r_op != 2'b01) begin
            r_rd_pend <= 1'b1;
            r_rd_core <= r_core;
          end
        end
`ifdef DMEM_BIT_RMW_EN
        S_BRD:  r_state <= S_BMOD;
        S_BMOD: begin
          r_state <= S_BWR;
          M_DI    <= w_rmw;
          M_WE    <= 1'b1;
          C0_ACK  <= ~r_core;
          C1_ACK  <= r_core;
        end
        S_BWR:  r_state <= S_IDLE;
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed and random requests scored against a word-level memory model.
// Bit-write cases are included only when DMEM_BIT_RMW_EN is defined.
module tb_data_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int BW = 5;
`ifdef DMEM_BIT_RMW_EN
  localparam bit BIT_EN = 1'b1;
`else
  localparam bit BIT_EN = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          C0_REQ, C1_REQ, C0_BV, C1_BV;
  logic [1:0]    C0_OP, C1_OP;
  logic [AW-1:0] C0_A, C1_A;
  logic [DW-1:0] C0_DI, C1_DI;
  logic [BW-1:0] C0_BIT, C1_BIT;
  logic          C0_ACK, C1_ACK, C0_DV, C1_DV, M_WE;
  logic [DW-1:0] C0_DQ, C1_DQ, M_DI, M_DQ;
  logic [AW-1:0] M_A;

  always #5 CLK = ~CLK;

  data_mem_arbiter #(.AW(AW), .DW(DW), .BW(BW)) dut (
    .CLK(CLK), .RST(RST),
    .C0_REQ(C0_REQ), .C0_OP(C0_OP), .C0_A(C0_A), .C0_DI(C0_DI), .C0_BIT(C0_BIT), .C0_BV(C0_BV),
    .C1_REQ(C1_REQ), .C1_OP(C1_OP), .C1_A(C1_A), .C1_DI(C1_DI), .C1_BIT(C1_BIT), .C1_BV(C1_BV),
    .C0_ACK(C0_ACK), .C0_DQ(C0_DQ), .C0_DV(C0_DV),
    .C1_ACK(C1_ACK), .C1_DQ(C1_DQ), .C1_DV(C1_DV),
    .M_WE(M_WE), .M_A(M_A), .M_DI(M_DI), .M_DQ(M_DQ)
  );

  // Single-port memory with registered address.
  logic [DW-1:0] mem [0:65535];
  logic [AW-1:0] mem_ra = '0;
  always @(posedge CLK) begin
    if (M_WE) mem[M_A] <= M_DI;
    mem_ra <= M_A;
  end
  assign M_DQ = mem[mem_ra];

  typedef struct packed {
    logic          go;
    logic [1:0]    op;
    logic [AW-1:0] a;
    logic [DW-1:0] di;
    logic [BW-1:0] bt;
    logic          bv;
  } req_t;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [DW-1:0] ref_mem [0:65535];
  int            m_last;
  int            exp_ack[$];
  logic [DW-1:0] exp_dq0[$];
  logic [DW-1:0] exp_dq1[$];
  logic [AW+DW-1:0] exp_wr[$];
  req_t          NO = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event with nothing expected", nm);
  endtask

  function automatic bit is_bw(input logic [1:0] op);
    return BIT_EN && (op == 2'b10);
  endfunction

  function automatic req_t mk(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] di,
                              input logic [BW-1:0] bt, input logic bv);
    req_t r;
    r = '{go: 1'b1, op: op, a: a, di: di, bt: bt, bv: bv};
    return r;
  endfunction

  // Word-level effect of one granted request, applied in grant order.
  task automatic model(input int c, input req_t r);
    logic [DW-1:0] w;
    exp_ack.push_back(c);
    m_last = c;
    if (r.op == 2'b01) begin
      ref_mem[r.a] = r.di;
      exp_wr.push_back({r.a, r.di});
    end else if (is_bw(r.op)) begin
      w = ref_mem[r.a];
      w[r.bt] = r.bv;
      ref_mem[r.a] = w;
      exp_wr.push_back({r.a, w});
    end else if (c == 0) begin
      exp_dq0.push_back(ref_mem[r.a]);
    end else begin
      exp_dq1.push_back(ref_mem[r.a]);
    end
  endtask

  task automatic raise(input int c, input req_t r);
    if (c == 0) begin
      C0_OP = r.op; C0_A = r.a; C0_DI = r.di; C0_BIT = r.bt; C0_BV = r.bv; C0_REQ = 1'b1;
    end else begin
      C1_OP = r.op; C1_A = r.a; C1_DI = r.di; C1_BIT = r.bt; C1_BV = r.bv; C1_REQ = 1'b1;
    end
  endtask

  task automatic check_cleared(input string nm);
    chk({nm, "_strobes"}, {59'd0, C0_ACK, C1_ACK, C0_DV, C1_DV, M_WE}, 64'd0);
    chk({nm, "_m_a"}, M_A, 64'd0);
    chk({nm, "_m_di"}, M_DI, 64'd0);
    chk({nm, "_c0_dq"}, C0_DQ, 64'd0);
    chk({nm, "_c1_dq"}, C1_DQ, 64'd0);
  endtask

  // Called at a negedge with the arbiter idle; stag delays C1 by one cycle.
  task automatic phase(input req_t r0, input req_t r1, input bit stag);
    int   lat0, lat1, dv, lat;
    bit   single, want_dv;
    req_t rs;
    lat0 = 0; lat1 = 0; dv = 0;
    single  = r0.go ^ r1.go;
    rs      = r0.go ? r0 : r1;
    want_dv = single && (rs.op != 2'b01) && !is_bw(rs.op);
    if (r0.go && r1.go) begin
      if (stag || m_last == 1) begin
        model(0, r0); model(1, r1);
      end else begin
        model(1, r1); model(0, r0);
      end
    end else if (r0.go) model(0, r0);
    else if (r1.go) model(1, r1);

    if (r0.go) raise(0, r0);
    if (r1.go && !stag) raise(1, r1);
    for (int k = 1; k <= 60; k++) begin
      @(negedge CLK);
      if (C0_REQ && C0_ACK) begin C0_REQ = 1'b0; lat0 = k; end
      if (C1_REQ && C1_ACK) begin C1_REQ = 1'b0; lat1 = k; end
      if (dv == 0 && ((r0.go && C0_DV) || (r1.go && C1_DV))) dv = k;
      if (r1.go && stag && k == 1) raise(1, r1);
      if ((!r0.go || lat0 != 0) && (!r1.go || lat1 != 0) && (!want_dv || dv != 0)) break;
    end
    C0_REQ = 1'b0;
    C1_REQ = 1'b0;
    if (r0.go) chk("c0_ack_seen", lat0 != 0, 64'd1);
    if (r1.go) chk("c1_ack_seen", lat1 != 0, 64'd1);
    if (single) begin
      lat = r0.go ? lat0 : lat1;
      chk("ack_latency", lat, is_bw(rs.op) ? 64'd3 : 64'd1);
      if (want_dv) chk("dv_latency", dv, 64'd3);
    end
    repeat (3) @(negedge CLK);
  endtask

  // Monitor: every strobe must match the head of its expectation queue.
  always @(negedge CLK) begin
    if (!RST) begin
      if (C0_ACK) begin
        if (exp_ack.size() == 0) unexpected("ack_c0");
        else chk("ack_order_c0", 0, exp_ack.pop_front());
      end
      if (C1_ACK) begin
        if (exp_ack.size() == 0) unexpected("ack_c1");
        else chk("ack_order_c1", 1, exp_ack.pop_front());
      end
      if (C0_DV) begin
        if (exp_dq0.size() == 0) unexpected("dv_c0");
        else chk("c0_dq", C0_DQ, exp_dq0.pop_front());
      end
      if (C1_DV) begin
        if (exp_dq1.size() == 0) unexpected("dv_c1");
        else chk("c1_dq", C1_DQ, exp_dq1.pop_front());
      end
      if (M_WE) begin
        if (exp_wr.size() == 0) unexpected("mem_write");
        else chk("mem_write", {M_A, M_DI}, exp_wr.pop_front());
      end
    end
  end

  initial begin
    logic [AW-1:0] addrs [4];
    req_t ra, rb;
    int   mode;
    addrs[0] = 16'h0010; addrs[1] = 16'h0020; addrs[2] = 16'h0030; addrs[3] = 16'h0040;
    for (int i = 0; i < 65536; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    {C0_REQ, C1_REQ, C0_BV, C1_BV} = '0;
    {C0_OP, C1_OP, C0_A, C1_A, C0_DI, C1_DI, C0_BIT, C1_BIT} = '0;
    m_last = 1;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    check_cleared("reset");
    RST = 1'b0;
    @(negedge CLK);

    phase(mk(2'b01, 16'h0010, 32'hDEADBEEF, 0, 0), NO, 0);
    phase(mk(2'b00, 16'h0010, 0, 0, 0), NO, 0);
    phase(mk(2'b00, 16'h0010, 0, 0, 0), mk(2'b00, 16'h0010, 0, 0, 0), 0);
    phase(mk(2'b11, 16'h0010, 0, 0, 0), mk(2'b00, 16'h0020, 0, 0, 0), 0);

`ifdef DMEM_BIT_RMW_EN
    phase(NO, mk(2'b10, 16'h0020, 0, 31, 1'b1), 0);
    phase(NO, mk(2'b10, 16'h0020, 0, 0, 1'b1), 0);
    phase(NO, mk(2'b10, 16'h0020, 0, 31, 1'b0), 0);
    phase(mk(2'b10, 16'h0020, 0, 4, 1'b1), mk(2'b01, 16'h0020, 32'hFFFFFFFF, 0, 0), 1);
    phase(mk(2'b00, 16'h0020, 0, 0, 0), NO, 0);
    // Reset lands while the RMW sits in BMOD.
    raise(0, mk(2'b10, 16'h0020, 0, 7, 1'b0));
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    C0_REQ = 1'b0;
    @(negedge CLK);
    check_cleared("rst_bmod");
    RST = 1'b0;
    m_last = 1;
    @(negedge CLK);
    phase(mk(2'b00, 16'h0020, 0, 0, 0), NO, 0);
`else
    phase(mk(2'b01, 16'h0030, 32'h12345678, 0, 0), NO, 0);
    phase(mk(2'b10, 16'h0030, 0, 3, 1'b0), NO, 0);
    RST = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    check_cleared("rst_idle");
    RST = 1'b0;
    m_last = 1;
    @(negedge CLK);
    phase(mk(2'b00, 16'h0030, 0, 0, 0), NO, 0);
`endif

    for (int it = 0; it < 60; it++) begin
      ra = mk(2'($urandom_range(0, 3)), addrs[$urandom_range(0, 3)], $urandom, 5'($urandom_range(0, 31)), 1'($urandom));
      rb = mk(2'($urandom_range(0, 3)), addrs[$urandom_range(0, 3)], $urandom, 5'($urandom_range(0, 31)), 1'($urandom));
      mode = $urandom_range(0, 3);
      if (mode == 0) rb = NO;
      else if (mode == 1) ra = NO;
      phase(ra, rb, (mode == 3));
    end

    repeat (4) @(negedge CLK);
    chk("ack_queue_drained", exp_ack.size(), 64'd0);
    chk("dq0_queue_drained", exp_dq0.size(), 64'd0);
    chk("dq1_queue_drained", exp_dq1.size(), 64'd0);
    chk("wr_queue_drained", exp_wr.size(), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
